// File: rtl/emu_ctrl_pkg.sv
// Shared command/state types and default sizes for the emulation run controller.
package emu_ctrl_pkg;

   localparam int unsigned CYCLE_WIDTH_DEF  = 64;
   localparam int unsigned LOAD_WIDTH_DEF   = 64;
   localparam int unsigned FF_WORDS_DEF     = 16;
   localparam int unsigned MEM_WORDS_DEF    = 16;
   localparam int unsigned RESET_CYCLES_DEF = 8;

   typedef enum logic [1:0] {
      OP_RUN      = 2'd0,
      OP_SCAN_IN  = 2'd1,
      OP_SCAN_OUT = 2'd2,
      OP_RSVD     = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_SCAN_IN,
      ST_SCAN_OUT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/emu_skid1.sv
// One-entry valid/ready buffer; accepts a new word in the same cycle the held word drains.
module emu_skid1 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready_c,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   assign in_ready_c = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready_c) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/emu_run_ctrl.sv
// Sequences checkpoint load, gated run and checkpoint dump for one emulated design instance.
module emu_run_ctrl
   import emu_ctrl_pkg::*;
#(
   parameter int unsigned CYCLE_WIDTH  = CYCLE_WIDTH_DEF,
   parameter int unsigned LOAD_WIDTH   = LOAD_WIDTH_DEF,
   parameter int unsigned FF_WORDS     = FF_WORDS_DEF,
   parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF,
   parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [CYCLE_WIDTH-1:0] cmd_arg,
   input  logic                   din_valid,
   output logic                   din_ready,
   input  logic [LOAD_WIDTH-1:0]  din_data,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [LOAD_WIDTH-1:0]  dout_data,
   output logic                   chain_en,
   output logic                   chain_sel,
   output logic [LOAD_WIDTH-1:0]  chain_in,
   input  logic [LOAD_WIDTH-1:0]  chain_out,
   input  logic                   pause_req,
   output logic                   dut_clk_en,
   output logic                   dut_rst,
   output logic [CYCLE_WIDTH-1:0] cycle_count,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned WORDS  = FF_WORDS + MEM_WORDS;
   localparam int unsigned WCNT_W = $clog2(WORDS + 1);

   state_e                 state_q,  state_d;
   logic [CYCLE_WIDTH-1:0] cycle_q,  cycle_d;
   logic [CYCLE_WIDTH-1:0] remain_q, remain_d;
   logic [WCNT_W-1:0]      wcnt_q,   wcnt_d;
   logic                   skid_in_valid;
   logic                   skid_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cycle_q  <= '0;
         remain_q <= '0;
         wcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         cycle_q  <= cycle_d;
         remain_q <= remain_d;
         wcnt_q   <= wcnt_d;
      end
   end

   // Next state, counter updates and the same-cycle handshake/strobe outputs.
   always_comb begin
      state_d       = state_q;
      cycle_d       = cycle_q;
      remain_d      = remain_q;
      wcnt_d        = wcnt_q;
      cmd_ready     = 1'b0;
      din_ready     = 1'b0;
      chain_en      = 1'b0;
      chain_sel     = 1'b0;
      chain_in      = '0;
      dut_clk_en    = 1'b0;
      skid_in_valid = 1'b0;
      done          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  OP_RUN: begin
                     remain_d = cmd_arg;
                     state_d  = ST_RUN;
                  end
                  OP_SCAN_IN: begin
                     cycle_d = cmd_arg;
                     wcnt_d  = '0;
                     state_d = ST_SCAN_IN;
                  end
                  OP_SCAN_OUT: begin
                     wcnt_d  = '0;
                     state_d = ST_SCAN_OUT;
                  end
                  OP_RSVD: state_d = ST_DONE;
               endcase
            end
         end

         ST_RUN: begin
            dut_clk_en = (remain_q != '0) && !pause_req;
            if (remain_q == '0) begin
               state_d = ST_DONE;
            end else if (!pause_req) begin
               cycle_d  = cycle_q + CYCLE_WIDTH'(1);
               remain_d = remain_q - CYCLE_WIDTH'(1);
            end
         end

         ST_SCAN_IN: begin
            din_ready = 1'b1;
            chain_sel = (wcnt_q >= WCNT_W'(FF_WORDS));
            chain_in  = din_data;
            if (din_valid) begin
               chain_en = 1'b1;
               wcnt_d   = wcnt_q + WCNT_W'(1);
               if (wcnt_q == WCNT_W'(WORDS - 1)) state_d = ST_DONE;
            end
         end

         // Rotate the chain through the output buffer so DUT state survives the dump.
         ST_SCAN_OUT: begin
            chain_sel     = (wcnt_q >= WCNT_W'(FF_WORDS));
            chain_in      = chain_out;
            skid_in_valid = (wcnt_q != WCNT_W'(WORDS));
            if (skid_in_valid && skid_in_ready) begin
               chain_en = 1'b1;
               wcnt_d   = wcnt_q + WCNT_W'(1);
            end
            if ((wcnt_q == WCNT_W'(WORDS)) && dout_valid && dout_ready) state_d = ST_DONE;
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign cycle_count = cycle_q;
   assign dut_rst     = (cycle_q < CYCLE_WIDTH'(RESET_CYCLES));

   emu_skid1 #(
      .WIDTH(LOAD_WIDTH)
   ) u_dout_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (skid_in_valid),
      .in_ready_c (skid_in_ready),
      .in_data    (chain_out),
      .out_valid  (dout_valid),
      .out_ready  (dout_ready),
      .out_data   (dout_data)
   );

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed bench for emu_run_ctrl with a 32-word scan-chain model.
module tb_emu_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [63:0] cmd_arg;
   logic        din_valid;
   logic        din_ready;
   logic [63:0] din_data;
   logic        dout_valid;
   logic        dout_ready;
   logic [63:0] dout_data;
   logic        chain_en;
   logic        chain_sel;
   logic [63:0] chain_in;
   logic [63:0] chain_out;
   logic        pause_req;
   logic        dut_clk_en;
   logic        dut_rst;
   logic [63:0] cycle_count;
   logic        busy;
   logic        done;

   logic [63:0] chain_m [32];
   logic        preload;

   int n_checks = 0;
   int n_fail   = 0;

   emu_run_ctrl u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .din_data    (din_data),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .dout_data   (dout_data),
      .chain_en    (chain_en),
      .chain_sel   (chain_sel),
      .chain_in    (chain_in),
      .chain_out   (chain_out),
      .pause_req   (pause_req),
      .dut_clk_en  (dut_clk_en),
      .dut_rst     (dut_rst),
      .cycle_count (cycle_count),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scan-chain model: shift in at the tail, head word presented on chain_out.
   assign chain_out = chain_m[0];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) chain_m[i] <= 64'hA0 + 64'(i);
      end else if (chain_en) begin
         for (int i = 0; i < 31; i++) chain_m[i] <= chain_m[i+1];
         chain_m[31] <= chain_in;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [63:0] arg);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      #1 chk("cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [9:0]  en_tbl;
      logic [63:0] exp_cnt;
      int          idx;
      int          rx;
      int          shifts;
      bit          got_done;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
      din_valid = 1'b0; din_data = '0; dout_ready = 1'b0; pause_req = 1'b0; preload = 1'b0;

      // Reset values
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dut_rst", 64'(dut_rst), 64'd1);
      chk("rst_count", cycle_count, 64'd0);
      chk("rst_clk_en", 64'(dut_clk_en), 64'd0);
      chk("rst_dout_valid", 64'(dout_valid), 64'd0);
      chk("rst_din_ready", 64'(din_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: RUN 12, no pause
      send_cmd(2'd0, 64'd12);
      for (int i = 0; i < 12; i++) begin
         #1;
         chk("t1_clk_en", 64'(dut_clk_en), 64'd1);
         chk("t1_count", cycle_count, 64'(i));
         chk("t1_dut_rst", 64'(dut_rst), 64'(i < 8));
         chk("t1_busy", 64'(busy), 64'd1);
         @(negedge clk);
      end
      #1;
      chk("t1_clk_en_end", 64'(dut_clk_en), 64'd0);
      chk("t1_count_end", cycle_count, 64'd12);
      chk("t1_done_early", 64'(done), 64'd0);
      @(negedge clk); #1;
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_cmd_ready_done", 64'(cmd_ready), 64'd0);
      @(negedge clk); #1;
      chk("t1_done_once", 64'(done), 64'd0);
      chk("t1_idle", 64'(cmd_ready), 64'd1);

      // 2: RUN 5 with a 3-cycle pause after the 2nd enabled cycle
      send_cmd(2'd0, 64'd5);
      en_tbl  = 10'b0011100011;
      exp_cnt = 64'd12;
      for (int i = 0; i < 10; i++) begin
         pause_req = (i >= 2 && i <= 4);
         #1;
         chk("t2_clk_en", 64'(dut_clk_en), 64'(en_tbl[i]));
         chk("t2_count", cycle_count, exp_cnt);
         chk("t2_done", 64'(done), 64'(i == 9));
         if (en_tbl[i]) exp_cnt = exp_cnt + 64'd1;
         @(negedge clk);
      end
      pause_req = 1'b0;
      chk("t2_count_final", cycle_count, 64'd17);

      // 3: SCAN_IN 1000 with 32 words, irregular din_valid
      send_cmd(2'd1, 64'd1000);
      idx = 0;
      for (int c = 0; c < 300 && idx < 32; c++) begin
         din_valid = ($urandom_range(0, 2) != 0);
         din_data  = din_valid ? 64'h100 + 64'(idx) : 64'hDEAD;
         #1;
         chk("t3_din_ready", 64'(din_ready), 64'd1);
         chk("t3_chain_en", 64'(chain_en), 64'(din_valid));
         if (din_valid) begin
            chk("t3_chain_in", chain_in, 64'h100 + 64'(idx));
            chk("t3_chain_sel", 64'(chain_sel), 64'(idx >= 16));
            idx++;
         end
         @(negedge clk);
      end
      din_valid = 1'b0;
      #1;
      chk("t3_words", 64'(idx), 64'd32);
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_count", cycle_count, 64'd1000);
      chk("t3_din_ready_off", 64'(din_ready), 64'd0);
      chk("t3_chain_head", chain_m[0], 64'h100);
      chk("t3_chain_tail", chain_m[31], 64'h11F);

      // 4: SCAN_OUT of a preloaded chain with a 4-cycle dout stall
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      send_cmd(2'd2, 64'd0);
      rx = 0; shifts = 0; got_done = 1'b0;
      for (int c = 0; c < 200 && !got_done; c++) begin
         dout_ready = !(c >= 6 && c <= 9);
         #1;
         if (chain_en) shifts++;
         if (dout_valid) chk("t4_dout", dout_data, 64'hA0 + 64'(rx));
         if (dout_valid && dout_ready) rx++;
         if (done) got_done = 1'b1;
         else @(negedge clk);
      end
      dout_ready = 1'b0;
      chk("t4_done", 64'(got_done), 64'd1);
      chk("t4_rx", 64'(rx), 64'd32);
      chk("t4_shifts", 64'(shifts), 64'd32);
      for (int i = 0; i < 32; i++) chk("t4_chain_kept", chain_m[i], 64'hA0 + 64'(i));
      @(negedge clk); #1;
      chk("t4_idle", 64'(cmd_ready), 64'd1);

      // 5a: RUN 0 finishes two cycles after acceptance
      send_cmd(2'd0, 64'd0);
      #1;
      chk("t5_clk_en", 64'(dut_clk_en), 64'd0);
      chk("t5_done_early", 64'(done), 64'd0);
      @(negedge clk); #1;
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_clk_en2", 64'(dut_clk_en), 64'd0);
      chk("t5_count", cycle_count, 64'd1000);

      // 5b: preload the counter to all-ones, then RUN 1 wraps it
      send_cmd(2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         din_valid = 1'b1;
         din_data  = 64'h100 + 64'(i);
         @(negedge clk);
      end
      din_valid = 1'b0;
      #1;
      chk("t5_load_done", 64'(done), 64'd1);
      chk("t5_count_max", cycle_count, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t5_rst_max", 64'(dut_rst), 64'd0);
      send_cmd(2'd0, 64'd1);
      #1;
      chk("t5_wrap_en", 64'(dut_clk_en), 64'd1);
      @(negedge clk); #1;
      chk("t5_wrap_count", cycle_count, 64'd0);
      chk("t5_wrap_rst", 64'(dut_rst), 64'd1);
      chk("t5_wrap_en_off", 64'(dut_clk_en), 64'd0);
      @(negedge clk); #1;
      chk("t5_wrap_done", 64'(done), 64'd1);

      // 6: async reset during the 10th SCAN_IN word
      send_cmd(2'd1, 64'd77);
      for (int i = 0; i < 9; i++) begin
         din_valid = 1'b1;
         din_data  = 64'(i);
         @(negedge clk);
      end
      din_valid = 1'b1;
      din_data  = 64'd9;
      #1;
      chk("t6_chain_en_pre", 64'(chain_en), 64'd1);
      chk("t6_count_pre", cycle_count, 64'd77);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("t6_chain_en", 64'(chain_en), 64'd0);
      chk("t6_din_ready", 64'(din_ready), 64'd0);
      chk("t6_count", cycle_count, 64'd0);
      chk("t6_dut_rst", 64'(dut_rst), 64'd1);
      chk("t6_done", 64'(done), 64'd0);
      din_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         chk("t6_no_done", 64'(done), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_cmd(2'd0, 64'd3);
      #1;
      chk("t6_after_busy", 64'(busy), 64'd1);
      chk("t6_after_en", 64'(dut_clk_en), 64'd1);
      got_done = 1'b0;
      for (int c = 0; c < 20 && !got_done; c++) begin
         if (done) got_done = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
      chk("t6_after_done", 64'(got_done), 64'd1);
      chk("t6_after_count", cycle_count, 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
